// File: rtl/lock_ctrl.sv
// Lock controller: checks submitted codes, drives unlock/relock timing, counts failures
// and enforces alarm lockout. Define LOCK_PROG_CODE_EN to allow reprogramming while open.
module lock_ctrl #(
    parameter int unsigned           CODE_LEN       = 4,
    parameter int unsigned           MAX_ATTEMPTS   = 3,
    parameter int unsigned           UNLOCK_CYCLES  = 500,
    parameter int unsigned           LOCKOUT_CYCLES = 1000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                submit,
    input  logic                                full,
    input  logic [4*CODE_LEN-1:0]               entered_code,
    input  logic                                relock,
    input  logic                                prog,
    output logic                                unlocked,
    output logic                                alarm,
    output logic                                err,
    output logic                                clear_entry,
    output logic                                ready,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
    output logic                                prog_done
);

    localparam int unsigned CW   = 4 * CODE_LEN;
    localparam int unsigned AW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                    : LOCKOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] UnlockLoad  = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LockoutLoad = TW'(LOCKOUT_CYCLES);
    localparam logic [AW-1:0] MaxFails    = AW'(MAX_ATTEMPTS);

    typedef enum logic [1:0] {StIdle, StCheck, StOpen, StLockout} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cap_code_q, cap_code_d;
    logic          cap_full_q, cap_full_d;
    logic [AW-1:0] fail_q, fail_d, fail_inc;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          clear_q, clear_d;
    logic [CW-1:0] stored_code;

`ifdef LOCK_PROG_CODE_EN
    logic [CW-1:0] stored_code_q, stored_code_d;
    logic          prog_done_q, prog_done_d;

    assign stored_code = stored_code_q;
    assign prog_done   = prog_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_code_q <= DEFAULT_CODE;
            prog_done_q   <= 1'b0;
        end else begin
            stored_code_q <= stored_code_d;
            prog_done_q   <= prog_done_d;
        end
    end
`else
    logic unused_prog;

    assign stored_code = DEFAULT_CODE;
    assign prog_done   = 1'b0;
    assign unused_prog = prog;
`endif

    assign fail_inc = fail_q + AW'(1);

    always_comb begin
        state_d    = state_q;
        cap_code_d = cap_code_q;
        cap_full_d = cap_full_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        err_d      = 1'b0;
        clear_d    = 1'b0;
`ifdef LOCK_PROG_CODE_EN
        stored_code_d = stored_code_q;
        prog_done_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (submit) begin
                    state_d    = StCheck;
                    cap_code_d = entered_code;
                    cap_full_d = full;
                    clear_d    = 1'b1;
                end
            end
            StCheck: begin
                if (cap_full_q && (cap_code_q == stored_code)) begin
                    state_d = StOpen;
                    fail_d  = '0;
                    timer_d = UnlockLoad;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == MaxFails) begin
                        state_d = StLockout;
                        timer_d = LockoutLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOpen: begin
                // relock takes priority over programming and timer expiry
                if (relock) begin
                    state_d = StIdle;
`ifdef LOCK_PROG_CODE_EN
                end else if (prog && full) begin
                    stored_code_d = entered_code;
                    prog_done_d   = 1'b1;
                    clear_d       = 1'b1;
                    timer_d       = UnlockLoad;
`endif
                end else if (timer_q <= TW'(1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StLockout: begin
                if (timer_q <= TW'(1)) begin
                    state_d = StIdle;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cap_code_q <= '0;
            cap_full_q <= 1'b0;
            fail_q     <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_code_q <= cap_code_d;
            cap_full_q <= cap_full_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            clear_q    <= clear_d;
        end
    end

    assign unlocked      = (state_q == StOpen);
    assign alarm         = (state_q == StLockout);
    assign ready         = (state_q == StIdle);
    assign err           = err_q;
    assign clear_entry   = clear_q;
    assign attempts_left = MaxFails - fail_q;

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Lock controller stage directly downstream of the digit-entry shift register.
- On submit, takes the assembled entered_code and compares it against the stored code.
- Drives the unlock output and a relock timer, counts failed attempts, and enforces an alarm lockout.
- Pulses clear_entry back upstream after every accepted submit.

Parameters:
- CODE_LEN, 4, number of 4-bit digits in a code.
- MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (at least 1).
- UNLOCK_CYCLES, 500, clock cycles the lock stays open (at least 1).
- LOCKOUT_CYCLES, 1000, clock cycles of alarm lockout (at least 1).
- DEFAULT_CODE, 16'h1234, stored code after reset; width 4*CODE_LEN.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- submit  in  1  user submit request, level sampled each cycle.
- full  in  1  upstream reports CODE_LEN digits entered.
- entered_code  in  4*CODE_LEN  assembled code from the entry stage.
- relock  in  1  manual relock request while open.
- prog  in  1  code-program request (see Optional Feature).
- unlocked  out  1  lock open.
- alarm  out  1  lockout active.
- err  out  1  one-cycle wrong-code pulse.
- clear_entry  out  1  one-cycle pulse telling the entry stage to clear.
- ready  out  1  controller accepting submit (state IDLE).
- attempts_left  out  $clog2(MAX_ATTEMPTS+1)  MAX_ATTEMPTS minus failure count.
- prog_done  out  1  one-cycle pulse, new code stored.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; stored code = DEFAULT_CODE; fail count 0; timers 0.
  - unlocked=0, alarm=0, err=0, clear_entry=0, prog_done=0, ready=1, attempts_left=MAX_ATTEMPTS.
  - Reset mid-operation aborts any state immediately; the stored code reverts to DEFAULT_CODE.
- All outputs are registered, or decoded purely from registered state.
- States: IDLE, CHECK, OPEN, LOCKOUT.
- IDLE:
  - submit=1 at edge N: capture entered_code and full, go to CHECK.
  - clear_entry=1 for the cycle N to N+1.
  - submit=0: remain in IDLE.
- CHECK (exactly 1 cycle):
  - Match: requires captured full=1 and captured code == stored code.
    - On match, go to OPEN; unlocked=1 from edge N+1.
    - Fail count resets to 0; unlock timer loads UNLOCK_CYCLES.
  - Mismatch, or captured full=0: fail count increments; err=1 for one cycle.
    - If the new count equals MAX_ATTEMPTS: go to LOCKOUT, alarm=1, lockout timer loads LOCKOUT_CYCLES.
    - Otherwise return to IDLE.
- OPEN:
  - Timer decrements each cycle; unlocked stays high for exactly UNLOCK_CYCLES cycles, then IDLE.
  - relock=1 forces IDLE at the next edge; unlocked=0 from that edge.
  - submit is ignored.
- LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYCLES cycles, then IDLE.
  - On exit, fail count clears to 0.
  - submit and relock are ignored.
- submit is ignored outside IDLE; there is no queuing.
  - A submit held high across CHECK is therefore not re-accepted until the state returns to IDLE.
- ready=1 only in IDLE.
- attempts_left updates on the same edge as the fail count.
- Timer widths: $clog2(max cycles + 1); no wrap. A timer is reloaded only on state entry.

Optional Feature:
- Macro: LOCK_PROG_CODE_EN.
- When defined, in OPEN with prog=1 and full=1:
  - Stored code <= entered_code at that edge.
  - prog_done=1 and clear_entry=1 for one cycle.
  - Unlock timer reloads to UNLOCK_CYCLES; state stays OPEN.
- prog=1 with full=0 is ignored.
- If relock and prog are asserted in the same cycle, relock wins and the code is not stored.
- When undefined, prog is ignored, prog_done is tied 0, and the stored code is constant DEFAULT_CODE.

Test Plan:
- Reset, entered_code=16'h1234, full=1, submit pulse:
  - clear_entry pulses 1 cycle, unlocked=1 two edges after submit.
  - unlocked drops after exactly 500 cycles; ready returns to 1.
- Reset, entered_code=16'h1235, full=1, submit ×3 (each after ready=1):
  - err pulses each time; attempts_left 2, 1, 0.
  - After the third, alarm=1 for exactly 1000 cycles, then attempts_left=3.
- Correct code while open, then relock after 10 cycles: unlocked=0 next edge. Submit during OPEN and during LOCKOUT: no state change, no clear_entry.
- Two wrong codes, then 16'h1234: unlocked=1, attempts_left back to 3. submit with full=0: counts as failure, err=1.
- Assert rst_n=0 mid-LOCKOUT and mid-OPEN: alarm and unlocked drop asynchronously; outputs at reset values.
- With LOCK_PROG_CODE_EN, sequence:
  - Open with 16'h1234, then prog=1 with entered_code=16'h9876, full=1: prog_done pulse.
  - Relock, then submit 16'h1234: err.
  - Submit 16'h9876: unlocked.
  - Reset: 16'h1234 works again.
